// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use interlock, redirect flush, memory wait hold,
// operand forwarding selects and stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int XLEN         = 32,
  parameter int LOAD_LATENCY = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            dec_valid_i,
  input  logic [4:0]      dec_rs1_addr_i,
  input  logic [4:0]      dec_rs2_addr_i,
  input  logic            dec_rs1_used_i,
  input  logic            dec_rs2_used_i,
  input  logic            ex_valid_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic            ex_rf_we_i,
  input  logic            ex_is_load_i,
  input  logic            ex_redirect_i,
  input  logic            mem_valid_i,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic            mem_rf_we_i,
  input  logic            mem_busy_i,
  output logic            fetch_stall_o,
  output logic            decode_stall_o,
  output logic            decode_flush_o,
  output logic            execute_stall_o,
  output logic            execute_flush_o,
  output logic [1:0]      fwd_rs1_sel_o,
  output logic [1:0]      fwd_rs2_sel_o,
  output logic [1:0]      state_o,
  output logic [XLEN-1:0] stall_cycles_o,
  output logic [XLEN-1:0] flush_count_o
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_LOAD_STALL = 2'b01,
    ST_FLUSH      = 2'b10,
    ST_MEM_WAIT   = 2'b11
  } state_t;

  localparam logic [1:0] LOAD_INIT  = 2'(LOAD_LATENCY - 1);
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam bit         LOAD_MULTI  = (LOAD_LATENCY > 1);
  localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  state_t          state_q, state_d;
  state_t          saved_q, saved_d;
  state_t          eff_state;
  logic [1:0]      cnt_q, cnt_d;
  logic [4:0]      pending_rd_q, pending_rd_d;
  logic [XLEN-1:0] stall_cnt_q, flush_cnt_q;

  logic rs1_ex_match, rs2_ex_match, rs1_mem_match, rs2_mem_match;
  logic ex_fwd_ok, mem_fwd_ok;
  logic loaduse, redirect, redirect_accept;

  assign rs1_ex_match  = dec_valid_i & dec_rs1_used_i & (dec_rs1_addr_i == ex_rd_addr_i)
                         & (ex_rd_addr_i != 5'd0);
  assign rs2_ex_match  = dec_valid_i & dec_rs2_used_i & (dec_rs2_addr_i == ex_rd_addr_i)
                         & (ex_rd_addr_i != 5'd0);
  assign rs1_mem_match = dec_valid_i & dec_rs1_used_i & (dec_rs1_addr_i == mem_rd_addr_i)
                         & (mem_rd_addr_i != 5'd0);
  assign rs2_mem_match = dec_valid_i & dec_rs2_used_i & (dec_rs2_addr_i == mem_rd_addr_i)
                         & (mem_rd_addr_i != 5'd0);

  // A load's data is not available in execute, so it never forwards from there.
  assign ex_fwd_ok  = ex_valid_i & ex_rf_we_i & ~ex_is_load_i;
  assign mem_fwd_ok = mem_valid_i & mem_rf_we_i;

  assign loaduse  = ex_valid_i & ex_is_load_i & ex_rf_we_i & (rs1_ex_match | rs2_ex_match);
  assign redirect = ex_valid_i & ex_redirect_i;
  assign redirect_accept = redirect & ~mem_busy_i;

  // On leaving MEM_WAIT, sequencing resumes from the state held when the wait began.
  assign eff_state = (state_q == ST_MEM_WAIT) ? saved_q : state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      saved_q      <= ST_RUN;
      cnt_q        <= 2'd0;
      pending_rd_q <= 5'd0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      saved_q      <= saved_d;
      cnt_q        <= cnt_d;
      pending_rd_q <= pending_rd_d;
      stall_cnt_q  <= stall_cnt_q + XLEN'(fetch_stall_o);
      flush_cnt_q  <= flush_cnt_q + XLEN'(redirect_accept);
    end
  end

  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    cnt_d        = cnt_q;
    pending_rd_d = pending_rd_q;
    if (mem_busy_i) begin
      state_d = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT) saved_d = state_q;
    end else if (redirect) begin
      state_d = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
      cnt_d   = FLUSH_INIT;
    end else begin
      case (eff_state)
        ST_RUN: begin
          state_d = ST_RUN;
          if (loaduse) begin
            pending_rd_d = ex_rd_addr_i;
            state_d      = LOAD_MULTI ? ST_LOAD_STALL : ST_RUN;
            cnt_d        = LOAD_INIT;
          end
        end
        ST_LOAD_STALL, ST_FLUSH: begin
          if (cnt_q <= 2'd1) begin
            state_d = ST_RUN;
          end else begin
            state_d = eff_state;
            cnt_d   = cnt_q - 2'd1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    fetch_stall_o   = 1'b0;
    decode_stall_o  = 1'b0;
    decode_flush_o  = 1'b0;
    execute_stall_o = 1'b0;
    execute_flush_o = 1'b0;
    fwd_rs1_sel_o   = FWD_RF;
    fwd_rs2_sel_o   = FWD_RF;
    state_o         = state_q;
    if (rst_i) begin
      decode_flush_o  = 1'b1;
      execute_flush_o = 1'b1;
      state_o         = ST_RUN;
    end else begin
      if (rs1_ex_match & ex_fwd_ok)        fwd_rs1_sel_o = FWD_EX;
      else if (rs1_mem_match & mem_fwd_ok) fwd_rs1_sel_o = FWD_MEM;
      if (rs2_ex_match & ex_fwd_ok)        fwd_rs2_sel_o = FWD_EX;
      else if (rs2_mem_match & mem_fwd_ok) fwd_rs2_sel_o = FWD_MEM;

      if (mem_busy_i) begin
        fetch_stall_o   = 1'b1;
        decode_stall_o  = 1'b1;
        execute_stall_o = 1'b1;
      end else if (redirect) begin
        decode_flush_o  = 1'b1;
        execute_flush_o = 1'b1;
      end else begin
        case (eff_state)
          ST_RUN: begin
            if (loaduse) begin
              fetch_stall_o   = 1'b1;
              decode_stall_o  = 1'b1;
              execute_flush_o = 1'b1;
            end
          end
          ST_LOAD_STALL: begin
            fetch_stall_o   = 1'b1;
            decode_stall_o  = 1'b1;
            execute_flush_o = 1'b1;
          end
          ST_FLUSH: decode_flush_o = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;

  // A load-use stall only starts on a real (non-x0) destination.
  a_pending_rd_nonzero: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == ST_LOAD_STALL) |-> (pending_rd_q != 5'd0));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two parameterisations driven in lock-step, checked every
// cycle against a remaining-cycles model, plus hand-computed literal checkpoints.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       dec_valid, dec_rs1_used, dec_rs2_used;
  logic [4:0] dec_rs1, dec_rs2;
  logic       ex_valid, ex_rf_we, ex_is_load, ex_redirect;
  logic [4:0] ex_rd;
  logic       mem_valid, mem_rf_we, mem_busy;
  logic [4:0] mem_rd;

  // index 0: XLEN=32, LOAD_LATENCY=1, FLUSH_CYCLES=2; index 1: XLEN=4, LOAD_LATENCY=2, FLUSH_CYCLES=1
  logic        fs_o[2], ds_o[2], df_o[2], es_o[2], ef_o[2];
  logic [1:0]  f1_o[2], f2_o[2], st_o[2];
  logic [31:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;
  logic [31:0] sc_o[2], fc_o[2];
  assign sc_o[0] = sc_a;
  assign fc_o[0] = fc_a;
  assign sc_o[1] = {28'd0, sc_b};
  assign fc_o[1] = {28'd0, fc_b};

  pipeline_hazard_ctrl #(.XLEN(32), .LOAD_LATENCY(1), .FLUSH_CYCLES(2)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .dec_valid_i(dec_valid), .dec_rs1_addr_i(dec_rs1), .dec_rs2_addr_i(dec_rs2),
    .dec_rs1_used_i(dec_rs1_used), .dec_rs2_used_i(dec_rs2_used),
    .ex_valid_i(ex_valid), .ex_rd_addr_i(ex_rd), .ex_rf_we_i(ex_rf_we),
    .ex_is_load_i(ex_is_load), .ex_redirect_i(ex_redirect),
    .mem_valid_i(mem_valid), .mem_rd_addr_i(mem_rd), .mem_rf_we_i(mem_rf_we),
    .mem_busy_i(mem_busy),
    .fetch_stall_o(fs_o[0]), .decode_stall_o(ds_o[0]), .decode_flush_o(df_o[0]),
    .execute_stall_o(es_o[0]), .execute_flush_o(ef_o[0]),
    .fwd_rs1_sel_o(f1_o[0]), .fwd_rs2_sel_o(f2_o[0]), .state_o(st_o[0]),
    .stall_cycles_o(sc_a), .flush_count_o(fc_a)
  );

  pipeline_hazard_ctrl #(.XLEN(4), .LOAD_LATENCY(2), .FLUSH_CYCLES(1)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .dec_valid_i(dec_valid), .dec_rs1_addr_i(dec_rs1), .dec_rs2_addr_i(dec_rs2),
    .dec_rs1_used_i(dec_rs1_used), .dec_rs2_used_i(dec_rs2_used),
    .ex_valid_i(ex_valid), .ex_rd_addr_i(ex_rd), .ex_rf_we_i(ex_rf_we),
    .ex_is_load_i(ex_is_load), .ex_redirect_i(ex_redirect),
    .mem_valid_i(mem_valid), .mem_rd_addr_i(mem_rd), .mem_rf_we_i(mem_rf_we),
    .mem_busy_i(mem_busy),
    .fetch_stall_o(fs_o[1]), .decode_stall_o(ds_o[1]), .decode_flush_o(df_o[1]),
    .execute_stall_o(es_o[1]), .execute_flush_o(ef_o[1]),
    .fwd_rs1_sel_o(f1_o[1]), .fwd_rs2_sel_o(f2_o[1]), .state_o(st_o[1]),
    .stall_cycles_o(sc_b), .flush_count_o(fc_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     cfg_ll[2] = '{1, 2};
  int     cfg_fc[2] = '{2, 1};
  int     cfg_xl[2] = '{32, 4};
  int     ls_left[2] = '{0, 0};
  int     fl_left[2] = '{0, 0};
  bit     waiting[2] = '{0, 0};
  longint stalls[2]  = '{0, 0};
  longint flushes[2] = '{0, 0};

  function automatic logic [1:0] fwd_exp(input logic used, input logic [4:0] a);
    if (!dec_valid || !used || a == 5'd0) return 2'd0;
    if (ex_valid && ex_rf_we && !ex_is_load && a == ex_rd) return 2'd1;
    if (mem_valid && mem_rf_we && a == mem_rd) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic lu_now();
    logic m1, m2;
    m1 = dec_valid && dec_rs1_used && dec_rs1 == ex_rd && ex_rd != 5'd0;
    m2 = dec_valid && dec_rs2_used && dec_rs2 == ex_rd && ex_rd != 5'd0;
    return ex_valid && ex_is_load && ex_rf_we && (m1 || m2);
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic   lu, rd, e_fs, e_ds, e_df, e_es, e_ef;
      logic [1:0] e_st, e_f1, e_f2;
      longint modv;
      string  p;
      p    = (k == 0) ? "a." : "b.";
      lu   = lu_now();
      rd   = ex_valid && ex_redirect;
      e_fs = 0; e_ds = 0; e_df = 0; e_es = 0; e_ef = 0;
      e_st = 2'd0; e_f1 = 2'd0; e_f2 = 2'd0;
      if (rst) begin
        e_df = 1; e_ef = 1;
      end else begin
        e_f1 = fwd_exp(dec_rs1_used, dec_rs1);
        e_f2 = fwd_exp(dec_rs2_used, dec_rs2);
        if (waiting[k])          e_st = 2'd3;
        else if (ls_left[k] > 0) e_st = 2'd1;
        else if (fl_left[k] > 0) e_st = 2'd2;
        if (mem_busy) begin
          e_fs = 1; e_ds = 1; e_es = 1;
        end else if (rd) begin
          e_df = 1; e_ef = 1;
        end else if (ls_left[k] > 0 || (fl_left[k] == 0 && lu)) begin
          e_fs = 1; e_ds = 1; e_ef = 1;
        end else if (fl_left[k] > 0) begin
          e_df = 1;
        end
      end
      modv = longint'(1) << cfg_xl[k];
      check({p, "fetch_stall"},   32'(fs_o[k]), 32'(e_fs));
      check({p, "decode_stall"},  32'(ds_o[k]), 32'(e_ds));
      check({p, "decode_flush"},  32'(df_o[k]), 32'(e_df));
      check({p, "execute_stall"}, 32'(es_o[k]), 32'(e_es));
      check({p, "execute_flush"}, 32'(ef_o[k]), 32'(e_ef));
      check({p, "fwd_rs1"},       32'(f1_o[k]), 32'(e_f1));
      check({p, "fwd_rs2"},       32'(f2_o[k]), 32'(e_f2));
      check({p, "state"},         32'(st_o[k]), 32'(e_st));
      check({p, "stall_cycles"},  sc_o[k], 32'(stalls[k] % modv));
      check({p, "flush_count"},   fc_o[k], 32'(flushes[k] % modv));
      // advance the model past the coming clock edge
      if (rst) begin
        ls_left[k] = 0; fl_left[k] = 0; waiting[k] = 0; stalls[k] = 0; flushes[k] = 0;
      end else if (mem_busy) begin
        waiting[k] = 1;
        stalls[k]++;
      end else begin
        waiting[k] = 0;
        if (rd) begin
          fl_left[k] = cfg_fc[k] - 1;
          ls_left[k] = 0;
          flushes[k]++;
        end else if (ls_left[k] > 0) begin
          ls_left[k]--;
        end else if (fl_left[k] > 0) begin
          fl_left[k]--;
        end else if (lu) begin
          ls_left[k] = cfg_ll[k] - 1;
        end
        if (e_fs) stalls[k]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
    ex_valid = 0; ex_rd = 0; ex_rf_we = 0; ex_is_load = 0; ex_redirect = 0;
    mem_valid = 0; mem_rd = 0; mem_rf_we = 0; mem_busy = 0;
  endtask

  // lw x5 in execute, add x6,x5,x1 in decode
  task automatic load_use();
    idle();
    dec_valid = 1; dec_rs1 = 5'd5; dec_rs1_used = 1; dec_rs2 = 5'd1; dec_rs2_used = 1;
    ex_valid = 1; ex_is_load = 1; ex_rf_we = 1; ex_rd = 5'd5;
  endtask

  // execute bubbled; the load has moved on to memory; decode still holds its instruction
  task automatic load_moved();
    ex_valid = 0; ex_is_load = 0; ex_rf_we = 0; ex_rd = 5'd0;
    mem_valid = 1; mem_rf_we = 1; mem_rd = 5'd5;
  endtask

  task automatic redirect();
    idle();
    ex_valid = 1; ex_redirect = 1;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    #1;
    check("lit.rst_dflush", 32'(df_o[0]), 32'd1);
    check("lit.rst_eflush", 32'(ef_o[1]), 32'd1);
    check("lit.rst_fstall", 32'(fs_o[0]), 32'd0);
    tick(); tick();
    rst = 0;
    #1;
    check("lit.post_rst_state", 32'(st_o[0]), 32'd0);
    check("lit.post_rst_dflush", 32'(df_o[1]), 32'd0);
    check("lit.post_rst_sc", sc_o[0], 32'd0);

    // load-use hazard
    tick(); load_use(); #1;
    check("lit.lu_fstall_a", 32'(fs_o[0]), 32'd1);
    check("lit.lu_dstall_a", 32'(ds_o[0]), 32'd1);
    check("lit.lu_eflush_a", 32'(ef_o[0]), 32'd1);
    check("lit.lu_state_a", 32'(st_o[0]), 32'd0);
    tick(); load_moved(); #1;
    check("lit.lu2_fstall_a", 32'(fs_o[0]), 32'd0);
    check("lit.lu2_fstall_b", 32'(fs_o[1]), 32'd1);
    check("lit.lu2_state_b", 32'(st_o[1]), 32'd1);
    check("lit.lu2_fwd1_mem", 32'(f1_o[0]), 32'd2);
    check("lit.lu2_fwd2_rf", 32'(f2_o[0]), 32'd0);
    tick(); idle(); #1;
    check("lit.lu_sc_a", sc_o[0], 32'd1);
    check("lit.lu_sc_b", sc_o[1], 32'd2);
    check("lit.lu_state_b_run", 32'(st_o[1]), 32'd0);

    // redirect
    tick(); redirect(); #1;
    check("lit.rd_dflush_a", 32'(df_o[0]), 32'd1);
    check("lit.rd_eflush_a", 32'(ef_o[0]), 32'd1);
    tick(); idle(); #1;
    check("lit.rd1_state_a", 32'(st_o[0]), 32'd2);
    check("lit.rd1_dflush_a", 32'(df_o[0]), 32'd1);
    check("lit.rd1_eflush_a", 32'(ef_o[0]), 32'd0);
    check("lit.rd1_dflush_b", 32'(df_o[1]), 32'd0);
    check("lit.rd1_fc_a", fc_o[0], 32'd1);
    tick(); #1;
    check("lit.rd2_state_a", 32'(st_o[0]), 32'd0);

    // memory wait holding a redirect
    tick(); redirect(); mem_busy = 1; #1;
    check("lit.mw_fstall", 32'(fs_o[0]), 32'd1);
    check("lit.mw_estall", 32'(es_o[0]), 32'd1);
    check("lit.mw_dflush", 32'(df_o[0]), 32'd0);
    tick(); tick(); tick();
    tick(); mem_busy = 0; #1;
    check("lit.mw_state_a", 32'(st_o[0]), 32'd3);
    check("lit.mw_state_b", 32'(st_o[1]), 32'd3);
    check("lit.mw_acc_dflush", 32'(df_o[0]), 32'd1);
    check("lit.mw_acc_fstall", 32'(fs_o[0]), 32'd0);
    tick(); idle(); #1;
    check("lit.mw_after_state_a", 32'(st_o[0]), 32'd2);
    check("lit.mw_sc_a", sc_o[0], 32'd5);
    check("lit.mw_sc_b", sc_o[1], 32'd6);
    check("lit.mw_fc_b", fc_o[1], 32'd2);
    tick();

    // memory wait in the middle of a load stall
    tick(); load_use();
    tick(); load_moved(); mem_busy = 1;
    tick();
    tick(); mem_busy = 0; #1;
    check("lit.mwls_state_b", 32'(st_o[1]), 32'd3);
    check("lit.mwls_fstall_b", 32'(fs_o[1]), 32'd1);
    check("lit.mwls_fstall_a", 32'(fs_o[0]), 32'd0);
    tick(); idle(); #1;
    check("lit.mwls_sc_a", sc_o[0], 32'd8);
    check("lit.mwls_sc_b", sc_o[1], 32'd10);

    // memory wait in the middle of a flush
    tick(); redirect();
    tick(); idle(); mem_busy = 1;
    tick(); mem_busy = 0; #1;
    check("lit.mwfl_state_a", 32'(st_o[0]), 32'd3);
    check("lit.mwfl_dflush_a", 32'(df_o[0]), 32'd1);
    check("lit.mwfl_eflush_a", 32'(ef_o[0]), 32'd0);
    tick(); #1;
    check("lit.mwfl_state_a_run", 32'(st_o[0]), 32'd0);
    check("lit.mwfl_fc_a", fc_o[0], 32'd3);

    // redirect overriding a load stall
    tick(); load_use();
    tick(); load_moved(); ex_valid = 1; ex_redirect = 1; #1;
    check("lit.ovr_state_b", 32'(st_o[1]), 32'd1);
    check("lit.ovr_fstall_b", 32'(fs_o[1]), 32'd0);
    check("lit.ovr_eflush_b", 32'(ef_o[1]), 32'd1);
    tick(); idle(); #1;
    check("lit.ovr_state_b_run", 32'(st_o[1]), 32'd0);
    check("lit.ovr_fc_b", fc_o[1], 32'd4);

    // forwarding
    tick(); idle();
    ex_valid = 1; ex_rf_we = 1; ex_rd = 5'd7;
    mem_valid = 1; mem_rf_we = 1; mem_rd = 5'd7;
    dec_valid = 1; dec_rs1 = 5'd7; dec_rs1_used = 1; dec_rs2 = 5'd0; dec_rs2_used = 1; #1;
    check("lit.fwd_ex", 32'(f1_o[0]), 32'd1);
    check("lit.fwd_x0", 32'(f2_o[0]), 32'd0);
    tick(); ex_rf_we = 0; #1;
    check("lit.fwd_mem", 32'(f1_o[0]), 32'd2);
    tick(); dec_rs1_used = 0; #1;
    check("lit.fwd_unused", 32'(f1_o[1]), 32'd0);
    tick(); dec_rs1_used = 1; ex_rf_we = 1; ex_is_load = 1; #1;
    check("lit.fwd_load_mem", 32'(f1_o[0]), 32'd2);
    check("lit.fwd_load_stall", 32'(fs_o[0]), 32'd1);
    tick(); idle(); tick();

    // reset during a load stall
    tick(); load_use();
    tick(); load_moved(); rst = 1; #1;
    check("lit.rls_state_b", 32'(st_o[1]), 32'd0);
    check("lit.rls_fstall_b", 32'(fs_o[1]), 32'd0);
    check("lit.rls_dflush_b", 32'(df_o[1]), 32'd1);
    tick(); rst = 0; idle(); #1;
    check("lit.rls_after_state_b", 32'(st_o[1]), 32'd0);
    check("lit.rls_after_fstall_b", 32'(fs_o[1]), 32'd0);
    check("lit.rls_sc_b", sc_o[1], 32'd0);
    check("lit.rls_fc_a", fc_o[0], 32'd0);

    // mixed vectors; the 4-bit counters wrap along the way
    for (int i = 0; i < 400; i++) begin
      tick();
      rst          = ($urandom_range(0, 59) == 0);
      dec_valid    = ($urandom_range(0, 3) != 0);
      dec_rs1      = 5'($urandom_range(0, 3));
      dec_rs2      = 5'($urandom_range(0, 3));
      dec_rs1_used = $urandom_range(0, 1) == 1;
      dec_rs2_used = $urandom_range(0, 1) == 1;
      ex_valid     = ($urandom_range(0, 3) != 0);
      ex_rd        = 5'($urandom_range(0, 3));
      ex_rf_we     = $urandom_range(0, 1) == 1;
      ex_is_load   = ($urandom_range(0, 2) == 0);
      ex_redirect  = ($urandom_range(0, 5) == 0);
      mem_valid    = $urandom_range(0, 1) == 1;
      mem_rd       = 5'($urandom_range(0, 3));
      mem_rf_we    = $urandom_range(0, 1) == 1;
      mem_busy     = ($urandom_range(0, 4) == 0);
    end
    tick(); rst = 0; idle();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing controller for the fetch/decode/execute/memory core pipeline.
- Detects load-use hazards, execute-stage PC redirects and data-memory wait states.
- Drives per-stage stall/flush controls and operand-forwarding selects into decode/execute.
- Keeps stall and flush performance counters.

Parameters:
- XLEN, 32, data width of the performance counters.
- LOAD_LATENCY, 1, bubble cycles inserted per load-use hazard (1..3).
- FLUSH_CYCLES, 1, cycles decode output is killed after a redirect; covers fetch read latency (1..3).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- dec_valid_i  in  1  decode holds a valid instruction.
- dec_rs1_addr_i  in  5  decode rs1 index.
- dec_rs2_addr_i  in  5  decode rs2 index.
- dec_rs1_used_i  in  1  instruction reads rs1.
- dec_rs2_used_i  in  1  instruction reads rs2.
- ex_valid_i  in  1  execute holds a valid instruction.
- ex_rd_addr_i  in  5  execute destination.
- ex_rf_we_i  in  1  execute writes the register file.
- ex_is_load_i  in  1  execute instruction is a load.
- ex_redirect_i  in  1  execute next_pc_enable (taken branch/jump).
- mem_valid_i  in  1  memory stage valid.
- mem_rd_addr_i  in  5  memory destination.
- mem_rf_we_i  in  1  memory stage writes the register file.
- mem_busy_i  in  1  data memory not ready; memory stage must hold.
- fetch_stall_o  out  1  hold PC and fetch register.
- decode_stall_o  out  1  hold decode register.
- decode_flush_o  out  1  load a bubble into the decode output register.
- execute_stall_o  out  1  hold execute register.
- execute_flush_o  out  1  load a bubble into the execute output register.
- fwd_rs1_sel_o  out  2  00 regfile, 01 execute result, 10 memory result.
- fwd_rs2_sel_o  out  2  same encoding as fwd_rs1_sel_o.
- state_o  out  2  00 RUN, 01 LOAD_STALL, 10 FLUSH, 11 MEM_WAIT.
- stall_cycles_o  out  XLEN  cycles with fetch_stall_o=1.
- flush_count_o  out  XLEN  accepted redirects.

Behaviour:
- Reset (rst_i=1 at a clock edge): state RUN, internal counter 0, pending rd 0, perf counters 0.
- While rst_i=1, outputs are driven combinationally to:
  - stalls 0,
  - decode_flush_o=1, execute_flush_o=1,
  - fwd selects 00,
  - state_o 00.
- Reset asserted mid-stall or mid-flush aborts it immediately; no pending state survives.
- Control outputs are combinational from current state and inputs. State, counters and pending rd are registered.
- Hazard terms:
  - match(x, a) = dec_valid_i & x_used & (x_addr==a) & (a!=0).
  - loaduse = ex_valid_i & ex_is_load_i & ex_rf_we_i & (match(rs1, ex_rd) | match(rs2, ex_rd)).
  - redirect = ex_valid_i & ex_redirect_i.
- Per-cycle priority (highest first):
  - 1. mem_busy_i=1: all stalls 1, both flushes 0. Next state MEM_WAIT. Redirect and loaduse are not evaluated (execute is held, so they persist).
  - 2. redirect: stalls 0, decode_flush_o=1, execute_flush_o=1, flush_count_o+1.
    - FLUSH_CYCLES>1: next state FLUSH with counter=FLUSH_CYCLES-1. Otherwise next state RUN.
    - Redirect overrides an in-progress LOAD_STALL or FLUSH (wrong-path work).
  - 3. loaduse (RUN only): fetch_stall_o=1, decode_stall_o=1, execute_flush_o=1.
    - Latch pending rd=ex_rd_addr_i.
    - LOAD_LATENCY>1: next state LOAD_STALL with counter=LOAD_LATENCY-1. Otherwise stay RUN.
  - 4. LOAD_STALL: same outputs as 3. Counter decrements; return to RUN when counter reaches 1.
  - 5. FLUSH: stalls 0, decode_flush_o=1. Counter decrements; return to RUN when counter reaches 1.
  - 6. RUN with no event: all controls 0.
- Leaving MEM_WAIT: when mem_busy_i drops, evaluate priorities 2-6 from the state held before MEM_WAIT, which is saved on entry.
- Forwarding (always evaluated; ignores stalls):
  - Select 01 if ex_valid_i & ex_rf_we_i & !ex_is_load_i & match(rsN, ex_rd).
  - Else 10 if mem_valid_i & mem_rf_we_i & match(rsN, mem_rd).
  - Else 00.
  - Execute has priority over memory for the same register. x0 never forwards.
- stall_cycles_o increments every cycle fetch_stall_o=1 and rst_i=0.
- Both perf counters wrap modulo 2^XLEN without saturation.

Test Plan:
- Reset held 3 cycles, then released with idle inputs -> during reset flushes=1, stalls=0; after release state_o=00, all controls 0, counters 0.
- ex load (lw x5) with decode add x6,x5,x1, LOAD_LATENCY=1 -> one cycle fetch/decode stall with execute_flush_o=1, stall_cycles_o=1, state stays RUN.
- Same hazard with LOAD_LATENCY=2 -> 2 stall cycles, state_o=01 for one cycle, then RUN.
- ex_redirect_i=1 with FLUSH_CYCLES=2 -> cycle0 both flushes=1; cycle1 decode_flush_o=1, state_o=10; cycle2 RUN; flush_count_o=1.
- mem_busy_i high 4 cycles while a redirect sits in execute -> 4 full-stall cycles (state 11); redirect accepted on cycle 5; stall_cycles_o=4.
- add x7 in ex and x7 in mem, decode reads rs1=x7, rs2=x0 -> fwd_rs1_sel_o=01, fwd_rs2_sel_o=00. Drop ex_rf_we_i -> fwd_rs1_sel_o=10.
